// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding scoreboard.
package fwd_pkg;

    // Widest register address an entry can hold; narrower REG_W values are zero-extended.
    localparam int unsigned MAX_REG_W = 8;

    localparam int unsigned SEL_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 is_load;
        logic [MAX_REG_W-1:0] rd;
    } fwd_entry_t;

    function automatic int unsigned sel_w(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority scan of the in-flight writers for one source operand: youngest match wins,
// and a load that has not yet reached LOAD_STAGE reports a hazard instead of a select.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned SEL_W      = 2
) (
    input  fwd_entry_t [DEPTH-1:0] i_entries,
    input  logic       [REG_W-1:0] i_src,
    output logic       [SEL_W-1:0] o_sel,
    output logic                   o_hazard
);

    logic [MAX_REG_W-1:0] src_ext;
    logic                 found;

    assign src_ext = MAX_REG_W'(i_src);

    always_comb begin
        o_sel    = SEL_W'(SEL_RF);
        o_hazard = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (!found && i_entries[k].valid && i_entries[k].regwrite &&
                (i_entries[k].rd != '0) && (i_entries[k].rd == src_ext)) begin
                found = 1'b1;
                // Index k holds stage k+1.
                if (i_entries[k].is_load && ((k + 1) < int'(LOAD_STAGE))) begin
                    o_hazard = 1'b1;
                end else begin
                    o_sel = SEL_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Operand-forwarding and load-use stall unit tracking DEPTH producer stages.
// Optional saturating statistics counters are built when FWD_STATS_EN is defined.
module forwarding_scoreboard
    import fwd_pkg::*;
#(
    parameter  int unsigned NUM_SRC    = 2,
    parameter  int unsigned REG_W      = 5,
    parameter  int unsigned DEPTH      = 2,
    parameter  int unsigned LOAD_STAGE = 2,
    parameter  int unsigned CNT_W      = 32,
    localparam int unsigned SEL_W      = sel_w(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_advance,
    input  logic                     i_flush,
    input  logic                     i_cur_valid,
    input  logic                     i_cur_regwrite,
    input  logic                     i_cur_is_load,
    input  logic [REG_W-1:0]         i_cur_rd,
    input  logic [NUM_SRC*REG_W-1:0] i_cur_src,
    output logic [NUM_SRC*SEL_W-1:0] o_fwd_sel,
    output logic                     o_stall
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]         o_stall_cnt,
    output logic [CNT_W-1:0]         o_fwd_cnt
`endif
);

    fwd_entry_t [DEPTH-1:0] entries_q;
    fwd_entry_t             cur_entry;
    fwd_entry_t             new_entry;
    logic [NUM_SRC-1:0]     hazard;

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        fwd_src_match #(
            .REG_W      (REG_W),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .SEL_W      (SEL_W)
        ) u_match (
            .i_entries (entries_q),
            .i_src     (i_cur_src[j*REG_W +: REG_W]),
            .o_sel     (o_fwd_sel[j*SEL_W +: SEL_W]),
            .o_hazard  (hazard[j])
        );
    end

    assign o_stall = i_cur_valid & (|hazard);

    always_comb begin
        cur_entry.valid    = i_cur_valid;
        cur_entry.regwrite = i_cur_regwrite;
        cur_entry.is_load  = i_cur_is_load;
        cur_entry.rd       = MAX_REG_W'(i_cur_rd);
        // A stalled or flushed instruction leaves a single invalid bubble behind.
        new_entry          = (o_stall | i_flush) ? '0 : cur_entry;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            entries_q <= '0;
        end else if (i_advance) begin
            for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                entries_q[k] <= entries_q[k-1];
            end
            entries_q[0] <= new_entry;
        end
    end

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_q;
    logic             stall_evt;
    logic             fwd_evt;

    // A flush on the same edge as a stall counts as a flush only.
    assign stall_evt = i_advance & o_stall & ~i_flush;
    assign fwd_evt   = i_advance & i_cur_valid & ~i_flush & ~o_stall & (|o_fwd_sel);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (fwd_evt && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_fwd_cnt   = fwd_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: a default build and a deep (DEPTH=4, LOAD_STAGE=3) build.
module tb_forwarding_scoreboard;

    localparam int A_D = 2, A_LS = 2, A_SW = 2;
    localparam int B_D = 4, B_LS = 3, B_SW = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        adv, flush, valid, rw, ld;
    logic [4:0]  rd;
    logic [9:0]  src_a;
    logic [4:0]  src_extra;
    logic [14:0] src_b;
    logic [3:0]  sel_a;
    logic [8:0]  sel_b;
    logic        stall_a, stall_b;
`ifdef FWD_STATS_EN
    logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

    always #5 clk = ~clk;
    assign src_b = {src_extra, src_a};

    forwarding_scoreboard #(
        .NUM_SRC (2), .REG_W (5), .DEPTH (A_D), .LOAD_STAGE (A_LS), .CNT_W (32)
    ) u_dut_a (
        .i_clk (clk), .i_rst_n (rst_n), .i_advance (adv), .i_flush (flush),
        .i_cur_valid (valid), .i_cur_regwrite (rw), .i_cur_is_load (ld), .i_cur_rd (rd),
        .i_cur_src (src_a), .o_fwd_sel (sel_a), .o_stall (stall_a)
`ifdef FWD_STATS_EN
        , .o_stall_cnt (scnt_a), .o_fwd_cnt (fcnt_a)
`endif
    );

    forwarding_scoreboard #(
        .NUM_SRC (3), .REG_W (5), .DEPTH (B_D), .LOAD_STAGE (B_LS), .CNT_W (32)
    ) u_dut_b (
        .i_clk (clk), .i_rst_n (rst_n), .i_advance (adv), .i_flush (flush),
        .i_cur_valid (valid), .i_cur_regwrite (rw), .i_cur_is_load (ld), .i_cur_rd (rd),
        .i_cur_src (src_b), .o_fwd_sel (sel_b), .o_stall (stall_b)
`ifdef FWD_STATS_EN
        , .o_stall_cnt (scnt_b), .o_fwd_cnt (fcnt_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list of in-flight writers, index 0 = youngest (stage 1).
    typedef struct {
        bit v;
        bit w;
        bit l;
        int rd;
    } ment_t;

    ment_t ma[4];
    ment_t mb[4];
    int    m_stall_cnt, m_fwd_cnt;
    int    ex_sel_a, ex_sel_b;
    bit    ex_stall_a, ex_stall_b;

    function automatic void mexp(input bit use_b, input int src, output int sel, output bit hz);
        int    depth = use_b ? B_D : A_D;
        int    ls    = use_b ? B_LS : A_LS;
        bit    found = 0;
        ment_t e;
        sel = 0;
        hz  = 0;
        for (int k = 1; k <= depth; k++) begin
            e = use_b ? mb[k-1] : ma[k-1];
            if (!found && e.v && e.w && e.rd != 0 && e.rd == src) begin
                found = 1;
                if (e.l && k < ls) hz = 1;
                else sel = k;
            end
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            ma[k] = '{0, 0, 0, 0};
            mb[k] = '{0, 0, 0, 0};
        end
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
    endtask

    task automatic model_eval();
        int s;
        bit h, hz;
        ex_sel_a = 0;
        hz = 0;
        for (int j = 0; j < 2; j++) begin
            mexp(0, int'(src_a[j*5 +: 5]), s, h);
            ex_sel_a |= s << (j * A_SW);
            hz |= h;
        end
        ex_stall_a = valid && hz;
        ex_sel_b = 0;
        hz = 0;
        for (int j = 0; j < 3; j++) begin
            mexp(1, int'(src_b[j*5 +: 5]), s, h);
            ex_sel_b |= s << (j * B_SW);
            hz |= h;
        end
        ex_stall_b = valid && hz;
    endtask

    task automatic model_clock();
        ment_t cur;
        if (adv) begin
            if (ex_stall_a && !flush) m_stall_cnt++;
            if (valid && !flush && !ex_stall_a && ex_sel_a != 0) m_fwd_cnt++;
            cur = '{valid, rw, ld, int'(rd)};
            for (int k = A_D - 1; k > 0; k--) ma[k] = ma[k-1];
            ma[0] = (ex_stall_a || flush) ? '{0, 0, 0, 0} : cur;
            for (int k = B_D - 1; k > 0; k--) mb[k] = mb[k-1];
            mb[0] = (ex_stall_b || flush) ? '{0, 0, 0, 0} : cur;
        end
    endtask

    // Called a few ns after the inputs settle; checks both DUTs, then crosses one edge.
    task automatic step(input string tag);
        model_eval();
        chk({tag, " sel_a"}, 32'(sel_a), 32'(ex_sel_a));
        chk({tag, " stall_a"}, 32'(stall_a), 32'(ex_stall_a));
        chk({tag, " sel_b"}, 32'(sel_b), 32'(ex_sel_b));
        chk({tag, " stall_b"}, 32'(stall_b), 32'(ex_stall_b));
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic drive(input bit a, input bit f, input bit v, input bit w, input bit l,
                         input int d, input int s0, input int s1, input int s2);
        adv = a; flush = f; valid = v; rw = w; ld = l; rd = 5'(d);
        src_a = {5'(s1), 5'(s0)};
        src_extra = 5'(s2);
    endtask

    typedef struct {
        bit         adv, flush, valid, rw, ld;
        int         rd, s0, s1;
        logic [3:0] esel;
        bit         estall;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int nst;

        tbl[0]  = '{1, 0, 1, 1, 0, 3, 0, 0, 4'b0000, 0};
        tbl[1]  = '{0, 0, 1, 0, 0, 0, 3, 0, 4'b0001, 0};
        tbl[2]  = '{1, 0, 1, 1, 0, 3, 0, 3, 4'b0100, 0};
        tbl[3]  = '{0, 0, 1, 0, 0, 0, 0, 3, 4'b0100, 0};
        tbl[4]  = '{1, 0, 1, 1, 0, 7, 0, 0, 4'b0000, 0};
        tbl[5]  = '{0, 0, 1, 0, 0, 0, 7, 3, 4'b1001, 0};
        tbl[6]  = '{1, 0, 1, 1, 0, 0, 0, 0, 4'b0000, 0};
        tbl[7]  = '{1, 0, 1, 0, 0, 4, 0, 0, 4'b0000, 0};
        tbl[8]  = '{0, 0, 1, 0, 0, 0, 0, 4, 4'b0000, 0};
        tbl[9]  = '{1, 0, 1, 1, 1, 5, 0, 0, 4'b0000, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 0, 5, 4'b0000, 1};
        tbl[11] = '{1, 0, 1, 1, 0, 6, 0, 5, 4'b0000, 1};
        tbl[12] = '{1, 0, 1, 1, 0, 6, 0, 5, 4'b1000, 0};
        tbl[13] = '{1, 0, 1, 1, 1, 8, 0, 0, 4'b0000, 0};
        tbl[14] = '{1, 1, 1, 1, 0, 6, 8, 0, 4'b0000, 1};
        tbl[15] = '{0, 0, 1, 0, 0, 0, 8, 6, 4'b0010, 0};
        tbl[16] = '{0, 1, 1, 1, 0, 9, 8, 0, 4'b0010, 0};

        // Reset and check the idle state.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 1, 1, 0, 3, 3, 3, 3);
        #3;
        chk("reset sel_a", 32'(sel_a), 32'd0);
        chk("reset stall_a", 32'(stall_a), 32'd0);
        chk("reset sel_b", 32'(sel_b), 32'd0);
`ifdef FWD_STATS_EN
        chk("reset stall_cnt", scnt_a, 32'd0);
        chk("reset fwd_cnt", fcnt_a, 32'd0);
`endif
        @(negedge clk);

        // Directed table for the default build.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].adv, tbl[i].flush, tbl[i].valid, tbl[i].rw, tbl[i].ld,
                  tbl[i].rd, tbl[i].s0, tbl[i].s1, 0);
            #3;
            chk($sformatf("tbl%0d sel", i), 32'(sel_a), 32'(tbl[i].esel));
            chk($sformatf("tbl%0d stall", i), 32'(stall_a), 32'(tbl[i].estall));
            step($sformatf("tbl%0d model", i));
        end
`ifdef FWD_STATS_EN
        chk("tbl stall_cnt", scnt_a, 32'd1);
        chk("tbl fwd_cnt", fcnt_a, 32'd2);
`endif

        // Randomized traffic against the model on a small register range.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            #3;
            step("rnd");
        end
`ifdef FWD_STATS_EN
        chk("rnd stall_cnt", scnt_a, 32'(m_stall_cnt));
        chk("rnd fwd_cnt", fcnt_a, 32'(m_fwd_cnt));
`endif

        // Deep build: load in stage 1 must stall exactly two advances, then forward from 3.
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 1, 1, 1, 9, 0, 0, 0);
        #3;
        step("deep load");
        drive(1, 0, 1, 1, 0, 10, 0, 0, 9);
        #3;
        chk("deep stall first", 32'(stall_b), 32'd1);
        chk("deep sel first", 32'(sel_b), 32'd0);
        nst = 0;
        for (int i = 0; i < 6 && stall_b; i++) begin
            nst++;
            step("deep hold");
            #3;
        end
        chk("deep stall advances", 32'(nst), 32'd2);
        chk("deep stall released", 32'(stall_b), 32'd0);
        chk("deep sel2", 32'(sel_b), 32'(3 << 6));

        // Reset in the middle of a hazard drops stall and selects before the next edge.
        @(negedge clk);
        drive(1, 0, 1, 1, 1, 9, 0, 0, 0);
        #3;
        step("rst load");
        drive(0, 0, 1, 0, 0, 0, 9, 0, 9);
        #3;
        chk("pre-rst stall_a", 32'(stall_a), 32'd1);
        chk("pre-rst stall_b", 32'(stall_b), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst stall_a", 32'(stall_a), 32'd0);
        chk("rst stall_b", 32'(stall_b), 32'd0);
        chk("rst sel_a", 32'(sel_a), 32'd0);
        chk("rst sel_b", 32'(sel_b), 32'd0);
        model_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/forwarding_scoreboard.md
# forwarding_scoreboard

Parametrised operand-forwarding and load-use hazard unit for the pipelined MIPS core. It sits beside the ID/EX → EX stage. It tracks in-flight register writers in an internal shift register of `DEPTH` stages and produces one forward-select per source operand of the instruction in ID/EX. It also raises a load-use stall and inserts the bubble itself, generalising the fixed two-stage, two-source forwarding logic to any depth and operand count.

## Interface
- `NUM_SRC`, 2: source operands per instruction.
- `REG_W`, 5: register address width.
- `DEPTH`, 2: producer stages tracked. Stage 1 = EX/MEM, stage `DEPTH` = last stage before the register file sees the write.
- `LOAD_STAGE`, 2: first stage whose entry holds valid load data; 1 ≤ `LOAD_STAGE` ≤ `DEPTH`.
- `CNT_W`, 32: statistics counter width.
- `SEL_W`, derived: `$clog2(DEPTH+1)`.

Ports:
- `i_clk`, in, 1: clock. One clock only.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_advance`, in, 1: pipeline moves one stage this cycle.
- `i_flush`, in, 1: kill the instruction currently in ID/EX.
- `i_cur_valid`, in, 1: ID/EX holds a real instruction.
- `i_cur_regwrite`, in, 1: that instruction writes a register.
- `i_cur_is_load`, in, 1: that instruction is a load.
- `i_cur_rd`, in, `REG_W`: its destination register.
- `i_cur_src`, in, `NUM_SRC*REG_W`: its source registers. Operand j is bits `[j*REG_W +: REG_W]`.
- `o_fwd_sel`, out, `NUM_SRC*SEL_W`: per operand, 0 = register file, k = stage k result.
- `o_stall`, out, 1: load-use hazard. Hold IF/ID and ID/EX.
- `o_stall_cnt`, out, `CNT_W`: only with `FWD_STATS_EN`.
- `o_fwd_cnt`, out, `CNT_W`: only with `FWD_STATS_EN`.

## Operation
- **Entry state.** Entry k (1..`DEPTH`) holds {valid, regwrite, is_load, rd}.
- **Match rule.** Entry k matches operand j when all of the following hold: valid, regwrite, rd ≠ 0, rd == src_j. An operand with src_j == 0 never matches.
- **Priority.** The lowest matching k (youngest producer) wins. Older matches are ignored.
- **Forward select.**
  - Winner not a load, or winner k ≥ `LOAD_STAGE`: sel_j = k.
  - No match: sel_j = 0.
- **Load-use hazard.**
  - Winner is a load with k < `LOAD_STAGE`: operand j is hazarded and sel_j = 0.
  - `o_stall` = OR of hazards over operands, gated by `i_cur_valid`.
- **Shift on `i_advance`.**
  - entry[k+1] ← entry[k] for k = 1..`DEPTH`−1. entry[`DEPTH`] falls out.
  - entry[1] ← current instruction fields, or an invalid bubble if `o_stall` or `i_flush` is high.
- **No advance.** Entries hold. `i_flush` without `i_advance` has no effect; the flush is sampled only with advance.
- **Stall release.** A stall lifts by itself: each advance moves the load one stage deeper until k ≥ `LOAD_STAGE`.
- **Simultaneous flush and stall.** A single bubble is inserted. The cycle counts as a flush and is not a stall event.

## Timing
- `o_fwd_sel` and `o_stall` are combinational from registered entries plus current `i_cur_*`. Zero-cycle latency.
- Entry updates occur on the rising edge of `i_clk`.
- Reset, asynchronous:
  - all entries go invalid;
  - `o_fwd_sel` = 0 and `o_stall` = 0 immediately;
  - counters go to 0.
- Reset asserted mid-hazard drops `o_stall` at once.
- Load-use penalty = `LOAD_STAGE`−1 advancing cycles. Defaults give 1 bubble.
- Counters saturate at all-ones; they do not wrap.

## Configuration
- Macro `FWD_STATS_EN`.
- **Defined.**
  - `o_stall_cnt` increments on each `i_advance` edge where `o_stall`=1 and `i_flush`=0.
  - `o_fwd_cnt` increments on each `i_advance` edge where `i_cur_valid`=1, no flush, no stall, and any sel_j ≠ 0.
- **Undefined.** Both ports and counters are absent. Forwarding behaviour is identical.

## Structure
- Shared package `fwd_pkg`:
  - entry struct typedef {valid, regwrite, is_load, rd};
  - `SEL_RF` = 0 constant;
  - `SEL_W` function.
- Sub-module `fwd_src_match`: one per operand via generate. It takes the entry array and src_j and returns {sel_j, hazard_j} using the priority scan. The top level holds the shift register, the bubble mux and the counters.

## Test plan
- Defaults. Advance with cur = {valid, regwrite, rd=3}, then present src0=3 → `o_fwd_sel`[0]=1, `o_stall`=0.
- rd=3 written in stage 1 and stage 2 (two back-to-back writers), src1=3 → sel1=1 (youngest); make stage 1 rd=7 → sel1=2.
- Writer with rd=0, or with regwrite=0, and src0=0 → sel0=0, no stall.
- Load rd=5 enters stage 1, src1=5 → `o_stall`=1, sel1=0.
  - Advance → entry1 bubble, load in stage 2.
  - Next cycle `o_stall`=0, sel1=2.
  - With `FWD_STATS_EN`, `o_stall_cnt`=1.
- `DEPTH`=4, `LOAD_STAGE`=3, `NUM_SRC`=3, load rd=9 in stage 1, src2=9 → stall held for exactly 2 advances, then sel2=3.
- Stall and `i_flush` together on an advance → one bubble, stall count unchanged. Then drop `i_rst_n` mid-hazard → all sel=0 and `o_stall`=0 before the next edge.
